// File: rtl/stage_if_fq.sv
// Instruction-fetch stage: request/grant instruction memory with multiple
// outstanding requests, prioritised redirects that discard stale responses,
// and an in-order fetch queue presenting {pc, pc+4, instr} to decode.
//
// state | meaning
// BOOT  | first cycle after reset release, no requests issued
// RUN   | normal fetch, held until reset
module stage_if_fq #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  PC_INIT   = 32'hBFC0_0000,
    parameter int unsigned        NUM_REDIR = 3,
    parameter int unsigned        FQ_DEPTH  = 4
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst_n,
    input  logic [NUM_REDIR-1:0]          redir_vld,
    input  logic [NUM_REDIR*ADDR_W-1:0]   redir_addr,
    output logic                          imem_req,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic                          imem_gnt,
    input  logic                          imem_rvalid,
    input  logic [INSTR_W-1:0]            imem_rdata,
    output logic                          if_o_valid,
    output logic [ADDR_W-1:0]             if_o_pc,
    output logic [ADDR_W-1:0]             if_o_pc_4,
    output logic [INSTR_W-1:0]            if_o_instr,
    input  logic                          id_ready
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic {BOOT, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       outst_q, outst_d;
    logic [CW-1:0]       drop_q, drop_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   pc_mem_q    [FQ_DEPTH];
    logic [INSTR_W-1:0]  instr_mem_q [FQ_DEPTH];

    logic                redir_any;
    logic [ADDR_W-1:0]   redir_tgt;
    logic                credit_ok;
    logic                grant;
    logic                rsp_ok;
    logic                push;
    logic                pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FQ_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Pick the redirect target; scanning downward lets the lowest index win.
    always_comb begin
        redir_any = |redir_vld;
        redir_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_vld[i]) begin
                redir_tgt = redir_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Queued entries plus in-flight requests never exceed the queue depth,
    // so a response always has a free slot to land in.
    assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(FQ_DEPTH);

    // FSM next state and request generation.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                state_d  = RUN;
                imem_req = !redir_any && credit_ok;
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem_addr = fetch_pc_q & ALIGN_MASK;
    assign grant     = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok    = imem_rvalid && (outst_q != '0);
    assign push      = rsp_ok && (drop_q == '0) && !redir_any;
    assign pop       = (count_q != '0) && id_ready && !redir_any;

    // Datapath next state: counters, pointers and the two PC trackers.
    always_comb begin
        outst_d    = outst_q + CW'(grant) - CW'(rsp_ok);
        drop_d     = drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fetch_pc_d = grant ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
        resp_pc_d  = push  ? resp_pc_q  + ADDR_W'(4) : resp_pc_q;
        if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (redir_any) begin
            // Everything still in flight after this cycle belongs to the old path.
            drop_d     = outst_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redir_tgt & ALIGN_MASK;
            resp_pc_d  = redir_tgt & ALIGN_MASK;
        end
    end

    // State and control registers.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= PC_INIT;
            resp_pc_q  <= PC_INIT;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q.
    always_ff @(posedge cpu_clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // When empty the head shows the next PC expected from memory.
    assign if_o_valid = (count_q != '0);
    assign if_o_pc    = if_o_valid ? pc_mem_q[rd_ptr_q] : resp_pc_q;
    assign if_o_pc_4  = if_o_pc + ADDR_W'(4);
    assign if_o_instr = if_o_valid ? instr_mem_q[rd_ptr_q] : '0;

    // Flag responses that arrive with no request outstanding.
    always @(posedge cpu_clk) begin
        if (cpu_rst_n && imem_rvalid) begin
            assert (outst_q != '0);
        end
    end

endmodule

// File: tb/tb_stage_if_fq.sv
// Bench for stage_if_fq: memory model with configurable latency, a scoreboard
// of expected fetch PCs and a table of redirect scenarios.
module tb_stage_if_fq;

    localparam logic [31:0] PC_INIT = 32'hBFC0_0000;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic [2:0]  redir_vld;
    logic [95:0] redir_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_o_valid;
    logic [31:0] if_o_pc;
    logic [31:0] if_o_pc_4;
    logic [31:0] if_o_instr;
    logic        id_ready;

    stage_if_fq dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst_n   (cpu_rst_n),
        .redir_vld   (redir_vld),
        .redir_addr  (redir_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_o_valid  (if_o_valid),
        .if_o_pc     (if_o_pc),
        .if_o_pc_4   (if_o_pc_4),
        .if_o_instr  (if_o_instr),
        .id_ready    (id_ready)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [2:0]  vld;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
        int          nout;
        int          lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } vec_t;

    rsp_t        mq[$];
    logic [31:0] exp_q[$];
    vec_t        vecs[4];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_gnt = 0;
    int          lat = 1;
    logic        gnt_en = 1'b0;
    logic        rdy = 1'b0;
    logic [2:0]  redir_v = '0;
    logic [31:0] ra0 = '0, ra1 = '0, ra2 = '0;
    logic [31:0] m_pc = PC_INIT;

    logic        s_req, s_valid;
    logic        gnt_seen = 1'b0, pop_seen = 1'b0;
    logic [31:0] gnt_addr, pop_pc, pop_pc4;
    int          gnt_cyc, pop_cyc;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle();
        logic [31:0] e;
        redir_vld  = redir_v;
        redir_addr = {ra2, ra1, ra0};
        id_ready   = rdy;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        imem_gnt = gnt_en;
        #1;
        s_req   = imem_req;
        s_valid = if_o_valid;
        if (imem_req && gnt_en) begin
            chk("imem_addr", imem_addr, m_pc);
            if (!gnt_seen) begin
                gnt_seen = 1'b1;
                gnt_addr = imem_addr;
                gnt_cyc  = cyc;
            end
            exp_q.push_back(m_pc);
            mq.push_back('{due: cyc + lat, data: instr_of(m_pc)});
            m_pc = m_pc + 32'd4;
            n_gnt++;
        end
        if (if_o_valid && rdy && redir_v == 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", if_o_pc, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", if_o_pc, e);
                chk("pop_pc_4", if_o_pc_4, e + 32'd4);
                chk("pop_instr", if_o_instr, instr_of(e));
            end
            if (!pop_seen) begin
                pop_seen = 1'b1;
                pop_pc   = if_o_pc;
                pop_pc4  = if_o_pc_4;
                pop_cyc  = cyc;
            end
        end
        if (redir_v != 3'b000) begin
            exp_q.delete();
            if (redir_v[0])      m_pc = ra0 & ~32'd3;
            else if (redir_v[1]) m_pc = ra1 & ~32'd3;
            else                 m_pc = ra2 & ~32'd3;
        end
        if (imem_rvalid) void'(mq.pop_front());
        @(posedge cpu_clk);
        cyc++;
        @(negedge cpu_clk);
    endtask

    task automatic drain();
        gnt_en = 1'b0;
        rdy    = 1'b1;
        for (int t = 0; t < 60 && (mq.size() != 0 || exp_q.size() != 0); t++) cycle();
        cycle();
        chk("drain", mq.size() + exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{vld: 3'b100, a0: 32'h0, a1: 32'h0, a2: 32'h0040_0020, nout: 2, lat: 4,
                    exp_pc: 32'h0040_0020, exp_pc4: 32'h0040_0024};
        vecs[1] = '{vld: 3'b110, a0: 32'h0, a1: 32'h0000_1003, a2: 32'h0000_2000, nout: 1, lat: 2,
                    exp_pc: 32'h0000_1000, exp_pc4: 32'h0000_1004};
        vecs[2] = '{vld: 3'b001, a0: 32'hFFFF_FFFC, a1: 32'h0, a2: 32'h0, nout: 0, lat: 1,
                    exp_pc: 32'hFFFF_FFFC, exp_pc4: 32'h0000_0000};
        vecs[3] = '{vld: 3'b011, a0: 32'h0000_0123, a1: 32'h0000_5000, a2: 32'h0, nout: 3, lat: 3,
                    exp_pc: 32'h0000_0120, exp_pc4: 32'h0000_0124};

        cpu_rst_n   = 1'b0;
        redir_vld   = '0;
        redir_addr  = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        repeat (2) @(negedge cpu_clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_o_valid, 0);
        chk("rst_pc", if_o_pc, PC_INIT);
        chk("rst_pc_4", if_o_pc_4, PC_INIT + 32'd4);
        chk("rst_addr", imem_addr, PC_INIT);
        @(negedge cpu_clk);

        // Boot: one idle cycle, then back-to-back fetch at latency 1.
        cpu_rst_n = 1'b1;
        gnt_en = 1'b1; lat = 1; rdy = 1'b1;
        cycle();
        chk("boot_req", s_req, 0);
        cycle();
        chk("run_req", s_req, 1);
        repeat (8) cycle();
        chk("b2b_grants", n_gnt, 9);
        chk("first_gnt_addr", gnt_addr, PC_INIT);
        chk("first_pop_pc", pop_pc, PC_INIT);
        chk("first_pop_pc_4", pop_pc4, PC_INIT + 32'd4);
        chk("first_pop_latency", pop_cyc - gnt_cyc, 2);

        // Stall: credit limit caps grants at the queue depth.
        drain();
        rdy = 1'b0; lat = 2; gnt_en = 1'b1; n_gnt = 0;
        repeat (12) cycle();
        chk("stall_grants", n_gnt, 4);
        chk("stall_req", s_req, 0);
        rdy = 1'b1;
        cycle();
        rdy = 1'b0;
        repeat (8) cycle();
        chk("one_pop_grants", n_gnt, 5);
        chk("one_pop_req", s_req, 0);

        // Redirect scenarios.
        for (int k = 0; k < 4; k++) begin
            drain();
            lat = vecs[k].lat; gnt_en = 1'b1; rdy = 1'b1;
            repeat (vecs[k].nout) cycle();
            gnt_en = 1'b0;
            redir_v = vecs[k].vld; ra0 = vecs[k].a0; ra1 = vecs[k].a1; ra2 = vecs[k].a2;
            cycle();
            chk($sformatf("v%0d_redir_req", k), s_req, 0);
            redir_v = '0;
            cycle();
            chk($sformatf("v%0d_flush", k), s_valid, 0);
            for (int t = 0; t < 20 && mq.size() != 0; t++) cycle();
            cycle();
            chk($sformatf("v%0d_drop", k), s_valid, 0);
            gnt_seen = 1'b0; pop_seen = 1'b0; gnt_en = 1'b1;
            for (int t = 0; t < 40 && !pop_seen; t++) cycle();
            chk($sformatf("v%0d_pop_seen", k), pop_seen, 1);
            chk($sformatf("v%0d_gnt_addr", k), gnt_addr, vecs[k].exp_pc);
            chk($sformatf("v%0d_pop_pc", k), pop_pc, vecs[k].exp_pc);
            chk($sformatf("v%0d_pop_pc_4", k), pop_pc4, vecs[k].exp_pc4);
            repeat (4) cycle();
        end

        // Async reset with a full queue and requests in flight.
        drain();
        rdy = 1'b0; lat = 3; gnt_en = 1'b1;
        repeat (3) cycle();
        #2 cpu_rst_n = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_valid", if_o_valid, 0);
        chk("mid_rst_pc", if_o_pc, PC_INIT);
        chk("mid_rst_addr", imem_addr, PC_INIT);
        imem_rvalid = 1'b0; imem_gnt = 1'b0;
        mq.delete(); exp_q.delete(); m_pc = PC_INIT;
        repeat (2) @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        rdy = 1'b1; lat = 1; gnt_en = 1'b1;
        gnt_seen = 1'b0; pop_seen = 1'b0;
        cycle();
        chk("reboot_req", s_req, 0);
        cycle();
        chk("rerun_req", s_req, 1);
        repeat (6) cycle();
        chk("reboot_gnt_addr", gnt_addr, PC_INIT);
        chk("reboot_pop_pc", pop_pc, PC_INIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
